gpio_access_arbiter15: RTL

- Two-requester arbiter and access sequencer for the GPIO lite subunit register port (read/write/addr/wdata in, registered rdata out).
- Lets the APB bridge (requester 0) and the power-management sequencer (requester 1) share one subunit instance.
- Every access is serialised into exactly one read or write strobe cycle, so the subunit's read-to-clear interrupt status is never hit twice per request.

---
 rtl/gpio_access_arbiter15.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gpio_access_arbiter15.sv
// gpio_access_arbiter15
// Two-requester arbiter and access sequencer for the GPIO lite subunit
// register port. Requester 0 is the APB bridge, requester 1 the
// power-management sequencer. Each granted request becomes exactly one
// read or write strobe cycle (ACCESS), followed by one acknowledge cycle
// (RESP). A read-to-clear status register is therefore never strobed
// twice for one request.
//
// Optional build macro: GPIO_ARB_LOCK_EN
//   When defined, a requester that completes an access with its lock input
//   high keeps exclusive ownership of the port for its following request.
//   This supports atomic read-modify-write sequences.
//   When undefined, lock0/lock1 are ignored.
module gpio_access_arbiter15 #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              pclk15,
    input  logic              n_reset15,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              gpio_read,
    output logic              gpio_write,
    output logic [ADDR_W-1:0] gpio_addr,
    output logic [DATA_W-1:0] gpio_wdata,
    input  logic [DATA_W-1:0] gpio_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;

    logic              last_grant;
    logic              grant_q;
    logic              wr_q;
    logic              sel;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef GPIO_ARB_LOCK_EN
    logic lock_vld;
    logic lock_owner;
    logic owner_req;

    assign owner_req = lock_owner ? req1 : req0;
`else
    logic unused_lock;

    assign unused_lock = lock0 | lock1;
`endif

    // Winner selection for the next IDLE grant.
    always_comb begin
        sel = 1'b0;
        if (req0 && req1) begin
            // Round-robin favours the requester that was not served last.
            sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else begin
            sel = ~req0;
        end
`ifdef GPIO_ARB_LOCK_EN
        // A lock owner that is still requesting excludes the other side.
        if (lock_vld && owner_req) begin
            sel = lock_owner;
        end
`endif
    end

    assign sel_wr    = sel ? wr1    : wr0;
    assign sel_addr  = sel ? addr1  : addr0;
    assign sel_wdata = sel ? wdata1 : wdata0;

    // Access sequencer: IDLE grants and latches; ACCESS strobes; RESP acks.
    always_ff @(posedge pclk15 or negedge n_reset15) begin
        if (!n_reset15) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            wr_q       <= 1'b0;
            gpio_read  <= 1'b0;
            gpio_write <= 1'b0;
            gpio_addr  <= '0;
            gpio_wdata <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
`ifdef GPIO_ARB_LOCK_EN
            lock_vld   <= 1'b0;
            lock_owner <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef GPIO_ARB_LOCK_EN
                    // Owner dropped its request: release the lock.
                    if (lock_vld && !owner_req) begin
                        lock_vld <= 1'b0;
                    end
`endif
                    if (req0 || req1) begin
                        // Latch the winner's fields; the strobe registers
                        // carry them during ACCESS.
                        grant_q    <= sel;
                        wr_q       <= sel_wr;
                        gpio_addr  <= sel_addr;
                        gpio_wdata <= sel_wdata;
                        gpio_read  <= ~sel_wr;
                        gpio_write <= sel_wr;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    gpio_read  <= 1'b0;
                    gpio_write <= 1'b0;
                    ack0       <= ~grant_q;
                    ack1       <= grant_q;
                    state      <= RESP;
                end
                RESP: begin
                    ack0       <= 1'b0;
                    ack1       <= 1'b0;
                    last_grant <= grant_q;
`ifdef GPIO_ARB_LOCK_EN
                    lock_vld   <= grant_q ? lock1 : lock0;
                    lock_owner <= grant_q;
`endif
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The subunit registers read data at the end of ACCESS, so it is
    // forwarded combinationally while the matching ack is high.
    assign rdata0 = (ack0 && !wr_q) ? gpio_rdata : '0;
    assign rdata1 = (ack1 && !wr_q) ? gpio_rdata : '0;
    assign busy   = (state != IDLE);

endmodule
